// File: rtl/mic1_pkg.sv
// Shared constants and types for the MIC-1 datapath with handshaked memory ports.
// B-bus source codes, C-bus enable bit positions and the port FSM state type.
package mic1_pkg;

    localparam logic [3:0] B_MDR  = 4'd0;
    localparam logic [3:0] B_PC   = 4'd1;
    localparam logic [3:0] B_MBR  = 4'd2;
    localparam logic [3:0] B_MBRU = 4'd3;
    localparam logic [3:0] B_SP   = 4'd4;
    localparam logic [3:0] B_LV   = 4'd5;
    localparam logic [3:0] B_CPP  = 4'd6;
    localparam logic [3:0] B_TOS  = 4'd7;
    localparam logic [3:0] B_OPC  = 4'd8;

    localparam int C_MAR = 0;
    localparam int C_MDR = 1;
    localparam int C_PC  = 2;
    localparam int C_SP  = 3;
    localparam int C_LV  = 4;
    localparam int C_CPP = 5;
    localparam int C_TOS = 6;
    localparam int C_OPC = 7;
    localparam int C_H   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } port_state_e;

endpackage

// File: rtl/mic1_datapath_mem_port.sv
// One variable-latency req/ack memory port: latches address and write data on an
// accepted command, holds them until ack, and flags illegal commands.
module mic1_mem_port
    import mic1_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cmd_rd,
    input  logic          cmd_wr,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          ack_i,
    output logic          req_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o,
    output logic          pend_o,
    output logic          done_o,
    output logic          err_o
);

    port_state_e   state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          start;

    // An illegal command leaves the FSM alone, so an ack in the same cycle still completes.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        start   = cmd_rd | cmd_wr;
        done_o  = (state_q == WAIT) && ack_i;
        err_o   = (cmd_rd && cmd_wr) || (start && (state_q == WAIT));
        if (state_q == WAIT) begin
            if (ack_i) begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        end else if (start && !err_o) begin
            state_d = WAIT;
            we_d    = cmd_wr;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign req_o   = (state_q == WAIT);
    assign pend_o  = (state_d == WAIT);
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/mic1_datapath_mem.sv
// MIC-1 register file and bus block with a data port (MAR/MDR) and an
// instruction port (PC/MBR), each a handshaked variable-latency transaction.
module mic1_datapath_mem
    import mic1_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MBR_W   = 8,
    parameter int IADDR_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  c_bus,
    input  logic [8:0]         c_en,
    input  logic [3:0]         b_sel,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic               mem_fetch,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [MBR_W-1:0]   imem_rdata,
    input  logic               imem_ack,
    output logic               busy,
    output logic               cmd_err,
    output logic [DATA_W-1:0]  a_bus,
    output logic [DATA_W-1:0]  b_bus,
    output logic [DATA_W-1:0]  pc_o,
    output logic [DATA_W-1:0]  mar_o,
    output logic [DATA_W-1:0]  mdr_o,
    output logic [DATA_W-1:0]  sp_o,
    output logic [DATA_W-1:0]  lv_o,
    output logic [DATA_W-1:0]  cpp_o,
    output logic [DATA_W-1:0]  tos_o,
    output logic [DATA_W-1:0]  opc_o
);

    logic [DATA_W-1:0] h_q, h_d, opc_q, opc_d, tos_q, tos_d, cpp_q, cpp_d;
    logic [DATA_W-1:0] lv_q, lv_d, sp_q, sp_d, pc_q, pc_d;
    logic [DATA_W-1:0] mdr_q, mdr_d, mar_q, mar_d;
    logic [MBR_W-1:0]  mbr_q, mbr_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;

    logic              d_pend, d_done, d_err;
    logic              i_pend, i_done, i_err;
    logic              i_we;
    logic [MBR_W-1:0]  i_wdata;
    logic              unused_ok;

    // Ports latch the post-edge MAR/MDR/PC so a same-cycle C write is what goes out.
    mic1_mem_port #(.AW(DATA_W), .DW(DATA_W)) u_dport (
        .clock   (clock),
        .reset_n (reset_n),
        .cmd_rd  (mem_rd),
        .cmd_wr  (mem_wr),
        .addr_i  (mar_d),
        .wdata_i (mdr_d),
        .ack_i   (dmem_ack),
        .req_o   (dmem_req),
        .we_o    (dmem_we),
        .addr_o  (dmem_addr),
        .wdata_o (dmem_wdata),
        .pend_o  (d_pend),
        .done_o  (d_done),
        .err_o   (d_err)
    );

    mic1_mem_port #(.AW(IADDR_W), .DW(MBR_W)) u_iport (
        .clock   (clock),
        .reset_n (reset_n),
        .cmd_rd  (mem_fetch),
        .cmd_wr  (1'b0),
        .addr_i  (pc_d[IADDR_W-1:0]),
        .wdata_i ('0),
        .ack_i   (imem_ack),
        .req_o   (imem_req),
        .we_o    (i_we),
        .addr_o  (imem_addr),
        .wdata_o (i_wdata),
        .pend_o  (i_pend),
        .done_o  (i_done),
        .err_o   (i_err)
    );

    assign unused_ok = &{1'b0, i_we, i_wdata};

    // Read data overrides a same-cycle C write to MDR, and that collision is flagged.
    always_comb begin
        h_d   = c_en[C_H]   ? c_bus : h_q;
        opc_d = c_en[C_OPC] ? c_bus : opc_q;
        tos_d = c_en[C_TOS] ? c_bus : tos_q;
        cpp_d = c_en[C_CPP] ? c_bus : cpp_q;
        lv_d  = c_en[C_LV]  ? c_bus : lv_q;
        sp_d  = c_en[C_SP]  ? c_bus : sp_q;
        pc_d  = c_en[C_PC]  ? c_bus : pc_q;
        mar_d = c_en[C_MAR] ? c_bus : mar_q;
        mdr_d = c_en[C_MDR] ? c_bus : mdr_q;
        if (d_done && !dmem_we) begin
            mdr_d = dmem_rdata;
        end
        mbr_d     = i_done ? imem_rdata : mbr_q;
        busy_d    = d_pend | i_pend;
        cmd_err_d = cmd_err_q | d_err | i_err | (d_done && !dmem_we && c_en[C_MDR]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_q       <= '0;
            opc_q     <= '0;
            tos_q     <= '0;
            cpp_q     <= '0;
            lv_q      <= '0;
            sp_q      <= '0;
            pc_q      <= '0;
            mdr_q     <= '0;
            mar_q     <= '0;
            mbr_q     <= '0;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            opc_q     <= opc_d;
            tos_q     <= tos_d;
            cpp_q     <= cpp_d;
            lv_q      <= lv_d;
            sp_q      <= sp_d;
            pc_q      <= pc_d;
            mdr_q     <= mdr_d;
            mar_q     <= mar_d;
            mbr_q     <= mbr_d;
            busy_q    <= busy_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    always_comb begin
        b_bus = '0;
        case (b_sel)
            B_MDR:   b_bus = mdr_q;
            B_PC:    b_bus = pc_q;
            B_MBR:   b_bus = {{(DATA_W-MBR_W){mbr_q[MBR_W-1]}}, mbr_q};
            B_MBRU:  b_bus = {{(DATA_W-MBR_W){1'b0}}, mbr_q};
            B_SP:    b_bus = sp_q;
            B_LV:    b_bus = lv_q;
            B_CPP:   b_bus = cpp_q;
            B_TOS:   b_bus = tos_q;
            B_OPC:   b_bus = opc_q;
            default: b_bus = '0;
        endcase
    end

    assign a_bus   = h_q;
    assign pc_o    = pc_q;
    assign mar_o   = mar_q;
    assign mdr_o   = mdr_q;
    assign sp_o    = sp_q;
    assign lv_o    = lv_q;
    assign cpp_o   = cpp_q;
    assign tos_o   = tos_q;
    assign opc_o   = opc_q;
    assign busy    = busy_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_mic1_datapath_mem.sv
// Self-checking bench for mic1_datapath_mem: directed scenarios plus randomized
// traffic compared against a transaction-level model of registers and ports.
module tb_mic1_datapath_mem;

    localparam int DW = 32;
    localparam int MW = 8;
    localparam int IW = 32;

    localparam int R_MAR = 0;
    localparam int R_MDR = 1;
    localparam int R_PC  = 2;
    localparam int R_H   = 8;

    logic          clock;
    logic          reset_n;
    logic [DW-1:0] c_bus;
    logic [8:0]    c_en;
    logic [3:0]    b_sel;
    logic          mem_rd, mem_wr, mem_fetch;
    logic          dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          dmem_ack;
    logic          imem_req;
    logic [IW-1:0] imem_addr;
    logic [MW-1:0] imem_rdata;
    logic          imem_ack;
    logic          busy, cmd_err;
    logic [DW-1:0] a_bus, b_bus;
    logic [DW-1:0] pc_o, mar_o, mdr_o, sp_o, lv_o, cpp_o, tos_o, opc_o;

    int errors = 0;
    int checks = 0;

    // Model state: registers indexed by their c_en bit, plus one record per port.
    logic [DW-1:0] m_reg [9];
    logic [MW-1:0] m_mbr;
    bit            m_dbusy, m_dwe, m_ibusy, m_err;
    logic [DW-1:0] m_daddr, m_dwdata;
    logic [IW-1:0] m_iaddr;

    mic1_datapath_mem #(.DATA_W(DW), .MBR_W(MW), .IADDR_W(IW)) dut (
        .clock(clock), .reset_n(reset_n), .c_bus(c_bus), .c_en(c_en), .b_sel(b_sel),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_fetch(mem_fetch),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .busy(busy), .cmd_err(cmd_err), .a_bus(a_bus), .b_bus(b_bus),
        .pc_o(pc_o), .mar_o(mar_o), .mdr_o(mdr_o), .sp_o(sp_o), .lv_o(lv_o),
        .cpp_o(cpp_o), .tos_o(tos_o), .opc_o(opc_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic model_reset();
        for (int k = 0; k < 9; k++) m_reg[k] = '0;
        m_mbr = '0; m_dbusy = 0; m_dwe = 0; m_ibusy = 0; m_err = 0;
        m_daddr = '0; m_dwdata = '0; m_iaddr = '0;
    endtask

    function automatic logic [DW-1:0] m_bbus(input logic [3:0] sel);
        int v;
        v = int'(m_mbr);
        case (sel)
            4'd0: return m_reg[1];
            4'd1: return m_reg[2];
            4'd2: begin
                if (v >= 128) v = v - 256;
                return DW'(v);
            end
            4'd3: return DW'(int'(m_mbr));
            4'd4: return m_reg[3];
            4'd5: return m_reg[4];
            4'd6: return m_reg[5];
            4'd7: return m_reg[6];
            4'd8: return m_reg[7];
            default: return '0;
        endcase
    endfunction

    task automatic model_edge();
        logic [DW-1:0] nr [9];
        bit was_d, was_i;
        if (!reset_n) return;
        nr = m_reg;
        for (int k = 0; k < 9; k++) if (c_en[k]) nr[k] = c_bus;
        was_d = m_dbusy;
        was_i = m_ibusy;
        if (was_d && dmem_ack) begin
            if (!m_dwe) begin
                nr[R_MDR] = dmem_rdata;
                if (c_en[R_MDR]) m_err = 1;
            end
            m_dbusy = 0;
        end
        if (mem_rd && mem_wr) m_err = 1;
        else if (mem_rd || mem_wr) begin
            if (was_d) m_err = 1;
            else begin
                m_dbusy = 1; m_dwe = mem_wr; m_daddr = nr[R_MAR]; m_dwdata = nr[R_MDR];
            end
        end
        if (was_i && imem_ack) begin
            m_mbr = imem_rdata;
            m_ibusy = 0;
        end
        if (mem_fetch) begin
            if (was_i) m_err = 1;
            else begin
                m_ibusy = 1; m_iaddr = nr[R_PC][IW-1:0];
            end
        end
        m_reg = nr;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        c_en = '0; mem_rd = 0; mem_wr = 0; mem_fetch = 0; dmem_ack = 0; imem_ack = 0;
    endtask

    task automatic apply_reset();
        reset_n = 0;
        model_reset();
        idle_inputs();
        #1;
        repeat (2) tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        logic [DW-1:0] taps [9];
        c_bus = '0; b_sel = '0; dmem_rdata = '0; imem_rdata = '0;
        apply_reset();
        #1;
        taps = '{mar_o, mdr_o, pc_o, sp_o, lv_o, cpp_o, tos_o, opc_o, a_bus};
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (taps[k] !== '0) begin
                errors++; $display("FAIL reset_tap%0d: got %h want 0", k, taps[k]);
            end
        end
        checks++;
        if ({dmem_req, imem_req, dmem_we, busy, cmd_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 00000", {dmem_req, imem_req, dmem_we, busy, cmd_err});
        end
        checks++;
        if (b_bus !== '0) begin errors++; $display("FAIL reset_bbus: got %h want 0", b_bus); end
    endtask

    task automatic test_read_flow();
        int busy_cycles = 0;
        apply_reset();
        c_bus = 32'h10; c_en = 9'(1 << R_MAR); mem_rd = 1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (dmem_req !== 1'b1) begin errors++; $display("FAIL rd_req: got %b want 1", dmem_req); end
        checks++;
        if (dmem_addr !== 32'h10) begin errors++; $display("FAIL rd_addr: got %h want 10", dmem_addr); end
        checks++;
        if (dmem_we !== 1'b0) begin errors++; $display("FAIL rd_we: got %b want 0", dmem_we); end
        for (int i = 0; i < 8 && busy === 1'b1; i++) begin
            busy_cycles++;
            if (busy_cycles == 4) begin dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; end
            tick();
            dmem_ack = 0;
        end
        checks++;
        if (busy_cycles != 4) begin errors++; $display("FAIL rd_busy_len: got %0d want 4", busy_cycles); end
        b_sel = 4'd0;
        #1;
        checks++;
        if (b_bus !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_mdr: got %h want deadbeef", b_bus); end
        checks++;
        if (dmem_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b want 0", dmem_req); end
    endtask

    task automatic test_extend();
        c_bus = 32'h40; c_en = 9'(1 << R_PC); mem_fetch = 1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL fetch_req: got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr);
        end
        imem_ack = 1; imem_rdata = 8'h9C;
        tick();
        imem_ack = 0;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL fetch_drop: got %b want 0", imem_req); end
        b_sel = 4'd2; #1;
        checks++;
        if (b_bus !== 32'hFFFFFF9C) begin errors++; $display("FAIL mbr_sext: got %h want ffffff9c", b_bus); end
        b_sel = 4'd3; #1;
        checks++;
        if (b_bus !== 32'h0000009C) begin errors++; $display("FAIL mbr_zext: got %h want 0000009c", b_bus); end
        b_sel = 4'd12; #1;
        checks++;
        if (b_bus !== 32'h0) begin errors++; $display("FAIL bsel_unused: got %h want 0", b_bus); end
    endtask

    task automatic test_back_to_back();
        c_bus = 32'h55AA; c_en = 9'(1 << R_MDR); mem_wr = 1; mem_fetch = 1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({dmem_req, imem_req, dmem_we} !== 3'b111) begin
            errors++; $display("FAIL conc_req: got %b want 111", {dmem_req, imem_req, dmem_we});
        end
        checks++;
        if (dmem_wdata !== 32'h55AA || dmem_addr !== 32'h10 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL conc_latch: got wd=%h a=%h ia=%h want 55aa 10 40", dmem_wdata, dmem_addr, imem_addr);
        end
        tick();
        dmem_ack = 1; imem_ack = 1; imem_rdata = 8'h33;
        tick();
        idle_inputs();
        checks++;
        if ({dmem_req, imem_req, busy, cmd_err} !== 4'b0) begin
            errors++; $display("FAIL conc_done: got %b want 0000", {dmem_req, imem_req, busy, cmd_err});
        end
        checks++;
        if (mdr_o !== 32'h55AA) begin errors++; $display("FAIL conc_mdr: got %h want 55aa", mdr_o); end
    endtask

    task automatic test_errors();
        apply_reset();
        dmem_ack = 1; imem_ack = 1;
        tick();
        idle_inputs();
        checks++;
        if ({busy, cmd_err} !== 2'b00) begin errors++; $display("FAIL stale_ack: got %b want 00", {busy, cmd_err}); end
        mem_rd = 1; mem_wr = 1;
        tick();
        idle_inputs();
        checks++;
        if ({dmem_req, cmd_err} !== 2'b01) begin errors++; $display("FAIL rdwr_err: got %b want 01", {dmem_req, cmd_err}); end
        c_bus = 32'h20; c_en = 9'(1 << R_MAR); mem_rd = 1;
        tick();
        c_bus = 32'h30;
        tick();
        idle_inputs();
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h20 || mar_o !== 32'h30) begin
            errors++; $display("FAIL busy_cmd: got req=%b a=%h mar=%h want 1 20 30", dmem_req, dmem_addr, mar_o);
        end
        dmem_ack = 1; dmem_rdata = 32'h12345678; c_en = 9'(1 << R_MDR); c_bus = 32'h1;
        tick();
        idle_inputs();
        checks++;
        if (mdr_o !== 32'h12345678 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL ack_vs_c: got mdr=%h req=%b want 12345678 0", mdr_o, dmem_req);
        end
        apply_reset();
        c_bus = 32'h24; c_en = 9'(1 << R_MAR); mem_rd = 1;
        tick();
        idle_inputs();
        dmem_ack = 1; dmem_rdata = 32'hCAFE0001; c_en = 9'(1 << R_MDR); c_bus = 32'h1;
        tick();
        idle_inputs();
        checks++;
        if (cmd_err !== 1'b1 || mdr_o !== 32'hCAFE0001) begin
            errors++; $display("FAIL collide: got err=%b mdr=%h want 1 cafe0001", cmd_err, mdr_o);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [DW-1:0] taps [9];
        apply_reset();
        c_bus = 32'hA5A5A5A5; c_en = 9'h1FF; mem_rd = 1;
        tick();
        idle_inputs();
        checks++;
        if (dmem_req !== 1'b1 || pc_o !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL mid_setup: got req=%b pc=%h want 1 a5a5a5a5", dmem_req, pc_o);
        end
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({dmem_req, busy} !== 2'b00) begin errors++; $display("FAIL mid_drop: got %b want 00", {dmem_req, busy}); end
        taps = '{mar_o, mdr_o, pc_o, sp_o, lv_o, cpp_o, tos_o, opc_o, a_bus};
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (taps[k] !== '0) begin errors++; $display("FAIL mid_tap%0d: got %h want 0", k, taps[k]); end
        end
        #1;
        reset_n = 1;
        dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
        tick();
        idle_inputs();
        checks++;
        if (mdr_o !== '0 || {busy, dmem_req, cmd_err} !== 3'b0) begin
            errors++; $display("FAIL late_ack: got mdr=%h ctl=%b want 0 000", mdr_o, {busy, dmem_req, cmd_err});
        end
    endtask

    task automatic test_random(input int ncycles);
        logic [DW-1:0] taps [9];
        apply_reset();
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            c_bus = $urandom();
            c_en = ($urandom_range(0, 3) == 0) ? 9'($urandom()) : 9'(1 << $urandom_range(0, 8));
            b_sel = 4'($urandom_range(0, 15));
            mem_rd = ($urandom_range(0, 9) == 0);
            mem_wr = ($urandom_range(0, 9) == 0);
            mem_fetch = ($urandom_range(0, 7) == 0);
            dmem_ack = m_dbusy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            imem_ack = m_ibusy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            dmem_rdata = $urandom();
            imem_rdata = 8'($urandom());
            #1;
            taps = '{mar_o, mdr_o, pc_o, sp_o, lv_o, cpp_o, tos_o, opc_o, a_bus};
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (taps[k] !== m_reg[k]) begin
                    errors++; $display("FAIL rand_reg%0d cyc%0d: got %h want %h", k, cyc, taps[k], m_reg[k]);
                end
            end
            checks++;
            if (b_bus !== m_bbus(b_sel)) begin
                errors++; $display("FAIL rand_bbus cyc%0d sel%0d: got %h want %h", cyc, b_sel, b_bus, m_bbus(b_sel));
            end
            checks++;
            if ({dmem_req, imem_req, busy, cmd_err, dmem_we} !==
                {m_dbusy, m_ibusy, m_dbusy | m_ibusy, m_err, m_dbusy & m_dwe}) begin
                errors++;
                $display("FAIL rand_ctl cyc%0d: got %b want %b", cyc, {dmem_req, imem_req, busy, cmd_err, dmem_we},
                         {m_dbusy, m_ibusy, m_dbusy | m_ibusy, m_err, m_dbusy & m_dwe});
            end
            if (m_dbusy) begin
                checks++;
                if (dmem_addr !== m_daddr || dmem_wdata !== m_dwdata) begin
                    errors++;
                    $display("FAIL rand_dlatch cyc%0d: got %h/%h want %h/%h", cyc, dmem_addr, dmem_wdata, m_daddr, m_dwdata);
                end
            end
            if (m_ibusy) begin
                checks++;
                if (imem_addr !== m_iaddr) begin
                    errors++; $display("FAIL rand_ilatch cyc%0d: got %h want %h", cyc, imem_addr, m_iaddr);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 0;
        test_reset();
        test_read_flow();
        test_extend();
        test_back_to_back();
        test_errors();
        test_reset_mid_op();
        test_random(400);
        test_random(400);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mic1_datapath_mem.md
Name: mic1_datapath_mem

Overview:
Parametrised successor to the MIC-1 register file and bus block. It holds H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR and MBR, drives the A and B buses, and latches the C bus under per-register enables. It adds two handshaked memory ports: a data port (rd/wr through MAR/MDR) and an instruction port (fetch through PC/MBR). Each port has a variable-latency req/ack FSM and a busy output that the microsequencer uses to stall.

Parameters:
DATA_W, 32, width of all datapath registers and buses
MBR_W, 8, instruction byte width; MBR/MBRU extend from this to DATA_W
IADDR_W, 32, instruction port address width (low IADDR_W bits of PC)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
c_bus  in  DATA_W  ALU/shifter result
c_en  in  9  write enables, bit order H,OPC,TOS,CPP,LV,SP,PC,MDR,MAR (bit 8..0)
b_sel  in  4  B-bus source select
mem_rd  in  1  start data read at MAR
mem_wr  in  1  start data write of MDR to MAR
mem_fetch  in  1  start instruction byte fetch at PC
dmem_req  out  1  data request, held until ack
dmem_we  out  1  1 = write, 0 = read; stable while dmem_req
dmem_addr  out  DATA_W  word address (latched MAR)
dmem_wdata  out  DATA_W  latched MDR
dmem_rdata  in  DATA_W  read data, valid on ack
dmem_ack  in  1  one-cycle completion strobe
imem_req  out  1  fetch request, held until ack
imem_addr  out  IADDR_W  latched PC
imem_rdata  in  MBR_W  fetched byte, valid on ack
imem_ack  in  1  one-cycle completion strobe
busy  out  1  OR of both ports not IDLE
cmd_err  out  1  sticky illegal-command flag
a_bus  out  DATA_W  always H
b_bus  out  DATA_W  selected B source
pc_o, mar_o, mdr_o, sp_o, lv_o, cpp_o, tos_o, opc_o  out  DATA_W each  always-on register taps

Behaviour:
- Reset (async assert): all registers, taps, a_bus and b_bus = 0; both FSMs IDLE; dmem_req, imem_req, dmem_we, busy and cmd_err = 0. Reset mid-transaction drops req immediately. A stale ack arriving after reset is ignored.
- C writes: on the clock edge, every register with its c_en bit set loads c_bus. Any combination of enables is legal.
- b_bus is combinational from b_sel:
  - 0 MDR, 1 PC, 2 MBR sign-extended, 3 MBRU zero-extended, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC.
  - 9..15 drive all zeros; the bus never floats.
- Each port FSM has states IDLE -> WAIT -> IDLE.
  - IDLE + command: go to WAIT. Latch addr/wdata from the post-edge register values, so a MAR/PC/MDR written by C in the same cycle is used. req rises the cycle after the command.
  - WAIT: req, addr, we and wdata are held constant. On ack, return to IDLE and drop req in that same edge's update.
  - Data read on ack: MDR <= dmem_rdata. This beats a simultaneous c_en[MDR] write, and cmd_err is set.
  - Fetch on ack: MBR <= imem_rdata.
  - Minimum command-to-data latency is 2 cycles (ack in the first req cycle).
- Illegal commands set cmd_err, which is sticky until reset. The command is ignored and the FSM state is unchanged. Cases:
  - mem_rd and mem_wr together;
  - mem_rd or mem_wr while the data port is WAIT;
  - mem_fetch while the instruction port is WAIT.
- The two ports are independent. A data op and a fetch may run concurrently, and both acks may arrive in the same cycle.
- An ack while IDLE is ignored and does not set an error.
- busy is registered. It is high from the cycle after an accepted command through the ack cycle.

Decomposition:
- mic1_pkg holds the b_sel encoding constants, c_en bit indices, and FSM state typedef {IDLE, WAIT}.
- Sub-module mic1_mem_port (params AW, DW) implements the req/ack FSM, address/data latches and the error detect. It is instantiated twice: data port with DW=DATA_W and we used; instruction port with DW=MBR_W and we tied 0.

Test Plan:
- Read flow: c_bus=0x10, c_en=MAR, mem_rd same cycle; ack after 3 cycles with rdata=0xDEADBEEF -> dmem_addr=0x10, dmem_we=0, busy high 4 cycles, then MDR=0xDEADBEEF on b_sel=0.
- Sign/zero extend: fetch with imem_rdata=0x9C -> b_sel=2 gives 0xFFFFFF9C, b_sel=3 gives 0x0000009C; b_sel=12 gives 0.
- Concurrency: mem_wr (MDR=0x55AA) plus mem_fetch in the same cycle, both acks in the same cycle -> both reqs drop together, busy falls, cmd_err=0.
- Errors: mem_rd+mem_wr together -> no req, cmd_err=1. Then mem_rd while data WAIT -> still one transaction. Read ack together with c_en[MDR], c_bus=1 -> MDR=rdata.
- Reset mid-op: assert reset_n=0 during data WAIT -> dmem_req=0 immediately, all taps 0. A late ack after release leaves MDR=0 and busy=0.
